// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - instruction fetch unit with prefetch FIFO; optional same-cycle bypass under FETCH_PREFETCH_BYPASS_EN
module fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        stall_i,
    input  logic        new_pc_i,
    input  logic [31:0] pc_i
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_pc_q [DEPTH];
    logic [31:0]   mem_pc_d [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];

    logic [CW:0]   occupancy;
    logic          handshake;
    logic          rsp_accept;
    logic          rsp_keep;
    logic          fifo_empty;
    logic          bypass_show;
    logic          bypass_consume;
    logic          push;
    logic          pop;
    logic [1:0]    unused_pc_lo;

    assign unused_pc_lo = pc_i[1:0];

    // Request generation, response classification and decode-facing outputs
    always_comb begin
        occupancy   = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_o  = !rst_i && (occupancy < (CW+1)'(DEPTH));
        imem_addr_o = fetch_pc_q;
        handshake   = imem_req_o && imem_gnt_i;
        // Responses with nothing outstanding are leftovers from before a reset.
        rsp_accept  = imem_rvalid_i && (outstanding_q != '0);
        rsp_keep    = rsp_accept && (discard_q == '0) && !new_pc_i;
        fifo_empty  = (count_q == '0);
`ifdef FETCH_PREFETCH_BYPASS_EN
        bypass_show = fifo_empty && rsp_keep;
`else
        bypass_show = 1'b0;
`endif
        bypass_consume = bypass_show && !stall_i;
        valid_o = !fifo_empty || bypass_show;
        if (!fifo_empty) begin
            instr_o = mem_instr_q[rd_ptr_q];
            pc_o    = mem_pc_q[rd_ptr_q];
        end else if (bypass_show) begin
            instr_o = imem_rdata_i;
            pc_o    = resp_pc_q;
        end else begin
            instr_o = NOP;
            pc_o    = last_pc_q;
        end
        push = rsp_keep && !bypass_consume;
        pop  = !fifo_empty && !stall_i && !new_pc_i;
    end

    // Next-state: PC counters, outstanding/discard accounting and FIFO update
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_pc_d      = mem_pc_q;
        mem_instr_d   = mem_instr_q;
        last_pc_d     = valid_o ? pc_o : last_pc_q;
        outstanding_d = outstanding_q + CW'(handshake) - CW'(rsp_accept);
        if (new_pc_i) begin
            // Everything still in flight, including this cycle's grant, is stale.
            fetch_pc_d = {pc_i[31:2], 2'b00};
            resp_pc_d  = {pc_i[31:2], 2'b00};
            discard_d  = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            if (handshake) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_accept && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (rsp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (push) begin
                mem_pc_d[wr_ptr_q]    = resp_pc_q;
                mem_instr_d[wr_ptr_q] = imem_rdata_i;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            last_pc_q     <= 32'h0000_0000;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            assert (!(push && (count_q == CW'(DEPTH))));
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            last_pc_q     <= last_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO payload storage; contents are meaningless until count marks them valid
    always_ff @(posedge clk_i) begin
        mem_pc_q    <= mem_pc_d;
        mem_instr_q <= mem_instr_d;
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - scoreboard bench for fetch_prefetch
module tb_fetch_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        stall_i;
    logic        new_pc_i;
    logic [31:0] pc_i;

    always #5 clk = ~clk;

    fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .stall_i(stall_i), .new_pc_i(new_pc_i), .pc_i(pc_i)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t  sb[$];
    mreq_t memq[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;
    logic gnt_en = 1'b1;

    logic        s_valid, s_req, s_hs, s_rv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        imem_gnt_i = gnt_en;
        if (!rst_i && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        @(negedge clk);
        s_valid = valid_o;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_pc    = pc_o;
        s_instr = instr_o;
        s_hs    = imem_req_o && imem_gnt_i;
        s_rv    = imem_rvalid_i;
        if (rst_i) begin
            sb.delete();
            memq.delete();
        end else begin
            if (s_valid && !stall_i && !new_pc_i) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL spurious_valid: observed pc %h expected no instruction", s_pc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_pc", s_pc, e.pc);
                    chk("sb_instr", s_instr, e.instr);
                end
            end
            if (s_hs) begin
                memq.push_back('{s_addr, cyc + lat});
                sb.push_back('{s_addr, mem_word(s_addr)});
            end
            if (new_pc_i) sb.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (s_valid) seen = 1'b1;
        end
        chk({tag, "_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            chk({tag, "_pc"}, s_pc, exp_pc);
            chk({tag, "_instr"}, s_instr, mem_word(exp_pc));
        end
    endtask

    initial begin
        logic [31:0] hold_pc, hold_instr;
        int nvalid;
        logic found;

        rst_i = 1'b1; stall_i = 1'b0; new_pc_i = 1'b0; pc_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        @(posedge clk); #1;
        tick();
        tick();
        chk("rst_req", {31'b0, s_req}, 32'd0);
        chk("rst_valid", {31'b0, s_valid}, 32'd0);

        // Streaming from reset: 1-cycle memory, grant always.
        rst_i = 1'b0;
        tick();
        chk("c0_valid", {31'b0, s_valid}, 32'd0);
        chk("c0_instr", s_instr, NOP);
        chk("c0_pc", s_pc, 32'h0);
        chk("c0_req", {31'b0, s_req}, 32'd1);
        chk("c0_addr", s_addr, RESET_PC);
        tick();
        chk("c1_valid", {31'b0, s_valid}, 32'd0);
        tick();
        chk("c2_valid", {31'b0, s_valid}, 32'd1);
        chk("c2_pc", s_pc, RESET_PC);
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_valid) nvalid++;
        end
        chk("throughput", nvalid, 32'd10);

        // Long stall: requests stop at DEPTH, head held.
        stall_i = 1'b1;
        tick();
        hold_pc = s_pc;
        hold_instr = s_instr;
        for (int k = 0; k < 9; k++) tick();
        chk("stall_req_drop", {31'b0, s_req}, 32'd0);
        chk("stall_valid", {31'b0, s_valid}, 32'd1);
        chk("stall_pc_hold", s_pc, hold_pc);
        chk("stall_instr_hold", s_instr, hold_instr);
        stall_i = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Redirect with two requests outstanding at slow memory.
        lat = 3;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (memq.size() == 2) found = 1'b1;
            else tick();
        end
        chk("two_outstanding", {31'b0, found}, 32'd1);
        gnt_en = 1'b0; new_pc_i = 1'b1; pc_i = 32'h0000_0103;
        tick();
        new_pc_i = 1'b0; gnt_en = 1'b1; lat = 1;
        tick();
        chk("post_redir_valid", {31'b0, s_valid}, 32'd0);
        wait_valid("redir103", 32'h0000_0100);
        for (int k = 0; k < 4; k++) tick();

        // Redirect coinciding with both a handshake and an rvalid.
        new_pc_i = 1'b1; pc_i = 32'h0000_0200;
        tick();
        chk("redir_hs", {31'b0, s_hs}, 32'd1);
        chk("redir_rv", {31'b0, s_rv}, 32'd1);
        new_pc_i = 1'b0;
        wait_valid("redir200", 32'h0000_0200);
        for (int k = 0; k < 4; k++) tick();

        // Address wrap at the top of the address space.
        new_pc_i = 1'b1; pc_i = 32'hFFFF_FFFC;
        tick();
        new_pc_i = 1'b0;
        tick();
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        chk("wrap_hs", {31'b0, s_hs}, 32'd1);
        tick();
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        for (int k = 0; k < 6; k++) tick();

        // Reset with three queued and one outstanding.
        stall_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (sb.size() == 4 && memq.size() == 1) found = 1'b1;
        end
        chk("fill_3q_1o", {31'b0, found}, 32'd1);
        rst_i = 1'b1; stall_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        chk("mrst_valid", {31'b0, s_valid}, 32'd0);
        chk("mrst_instr", s_instr, NOP);
        chk("mrst_pc", s_pc, 32'h0);
        chk("mrst_addr", s_addr, RESET_PC);
        wait_valid("mrst_first", RESET_PC);
        for (int k = 0; k < 8; k++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
